spu_window_stats: RTL and testbench
===================================

# spu_window_stats

Downstream statistics stage of the spatial processing unit. Consumes the registered 8-bit operand sums from the adder stage as a valid/ready stream, groups them into fixed windows of 2^WIN_LOG2 samples, and emits one record per window: sum, min, max and mean. Results leave through a single-entry output register under valid/ready handshake, and backpressure propagates to the input only at window close.

## Interface
- DATA_W, 8, sample width (matches adder-stage sum width)
- WIN_LOG2, 2, log2 of window length; WIN = 2^WIN_LOG2, legal 1..6
- ACC_W, DATA_W+WIN_LOG2, derived width of the window sum; never overflows
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample present
- in_ready  out  1  stage accepts sample this cycle
- in_data  in  DATA_W  unsigned sample
- clear  in  1  synchronous abort of the partial window; highest priority after reset
- out_valid  out  1  result record present
- out_ready  in  1  consumer takes record this cycle
- out_sum  out  ACC_W  window sum
- out_min  out  DATA_W  window minimum
- out_max  out  DATA_W  window maximum
- out_mean  out  DATA_W  out_sum >> WIN_LOG2 (truncating)

## Operation
- Accept: in_valid && in_ready at a rising edge of clk.
- State: count[WIN_LOG2-1:0], acc_sum, acc_min, acc_max, and an output register with out_valid.
- First sample of a window (count==0) loads acc_sum=in_data, acc_min=acc_max=in_data. Later samples do acc_sum+=in_data, acc_min=min, acc_max=max, all unsigned.
- Closing sample (count==WIN-1, accepted): the final sum/min/max, including this sample, load into the output register. out_valid is set. count wraps to 0. The accumulators are treated as empty.
- in_ready = (count != WIN-1) || !out_valid || out_ready. This is a combinational path from out_ready to in_ready; it is permitted and documented.
- Non-closing samples are always accepted, even while out_valid is held.
- Output drain: out_valid && out_ready clears out_valid unless a closing sample is accepted in the same cycle. In that case the new record replaces the old one and out_valid stays 1.
- Output record is stable while out_valid && !out_ready.
- clear: count goes to 0 and the partial window is discarded. in_ready is forced to 0 that cycle. A pending output record and out_valid are unaffected.
- Reset: count=0, accumulators=0, out_valid=0, out_sum/out_min/out_max/out_mean=0. A window in progress at reset is lost, with no partial output.

## Timing
- Latency: the record is visible the cycle after the closing sample is accepted.
- Throughput: one sample per cycle. One record per WIN cycles when out_ready is held 1.
- Stall: at most at the closing sample, while an undrained record is held.
- No combinational path from in_data to any output.

## Structure
- The shared package spu_pkg holds SPU_DATA_W=8 and SPU_WIN_LOG2_DEF=2. The adder stage uses the same SPU_DATA_W.
- One sub-module is natural: spu_minmax_acc. It contains count, acc_sum, acc_min and acc_max, and produces the closing flag plus next-value outputs.
- The top module contains the handshake logic and the output register.

## Test plan
- WIN=4, out_ready=1; samples 10,3,250,7 -> one cycle after 7 is accepted: out_sum=270, out_min=3, out_max=250, out_mean=67, out_valid for 1 cycle.
- Extremes 255,255,255,255 -> out_sum=1020, out_min=out_max=255, out_mean=255; then 0,0,0,0 -> out_sum=0, out_min=out_max=0.
- out_ready=0, stream 8 samples 1..8 continuously -> first record (sum 10) is held. Samples 5,6,7 are accepted. in_ready=0 while 8 is offered. Raising out_ready gives first the record with sum 10, then 8 is accepted the same cycle, then the record with sum 26.
- Back-to-back with out_ready=1, 12 samples -> exactly 3 records, 4 cycles apart, in_ready never 0.
- clear after 2 samples (9,9), then 1,2,3,4 -> single record with sum=10, min=1, max=4. The 9s are absent.
- Assert reset after 3 samples, with a record pending -> out_valid=0 and all outputs 0 immediately. The next 4 samples form a fresh window.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared constants for the spatial processing unit.
// Adder and statistics stages agree on sample width here.
package spu_pkg;
  localparam int SPU_DATA_W       = 8;
  localparam int SPU_WIN_LOG2_DEF = 2;
endpackage

// File: rtl/spu_minmax_acc.sv
// Window accumulator: sample count, running sum, min and max.
// Exposes values that include the current sample and the closing flag.
module spu_minmax_acc
  import spu_pkg::*;
#(
  parameter int DATA_W   = SPU_DATA_W,
  parameter int WIN_LOG2 = SPU_WIN_LOG2_DEF,
  parameter int ACC_W    = DATA_W + WIN_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] in_data,
  output logic              closing,
  output logic [ACC_W-1:0]  nxt_sum,
  output logic [DATA_W-1:0] nxt_min,
  output logic [DATA_W-1:0] nxt_max
);

  logic [WIN_LOG2-1:0] count;
  logic [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]   acc_min;
  logic [DATA_W-1:0]   acc_max;
  logic                first;
  logic [ACC_W-1:0]    ext;

  assign first   = (count == '0);
  assign closing = &count;
  assign ext     = ACC_W'(in_data);

  always_comb begin
    nxt_sum = acc_sum + ext;
    nxt_min = acc_min;
    nxt_max = acc_max;
    if (first) begin
      nxt_sum = ext;
      nxt_min = in_data;
      nxt_max = in_data;
    end else begin
      if (in_data < acc_min) nxt_min = in_data;
      if (in_data > acc_max) nxt_max = in_data;
    end
  end

  // count wraps naturally since the window is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
      if (closing) begin
        acc_sum <= '0;
        acc_min <= '0;
        acc_max <= '0;
      end else begin
        acc_sum <= nxt_sum;
        acc_min <= nxt_min;
        acc_max <= nxt_max;
      end
    end
  end

endmodule

// File: rtl/spu_window_stats.sv
// Windowed sum/min/max/mean over the adder-stage sample stream.
// Single-entry output register; input stalls only at window close.
module spu_window_stats
  import spu_pkg::*;
#(
  parameter int DATA_W   = SPU_DATA_W,
  parameter int WIN_LOG2 = SPU_WIN_LOG2_DEF,
  parameter int ACC_W    = DATA_W + WIN_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_mean
);

  logic              closing;
  logic              accept;
  logic              close_acc;
  logic [ACC_W-1:0]  nxt_sum;
  logic [DATA_W-1:0] nxt_min;
  logic [DATA_W-1:0] nxt_max;

  // out_ready reaches in_ready combinationally so a drain frees the slot
  assign in_ready  = !clear
                  && (!closing || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign close_acc = accept && closing;

  spu_minmax_acc #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2),
    .ACC_W    (ACC_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .accept  (accept),
    .in_data (in_data),
    .closing (closing),
    .nxt_sum (nxt_sum),
    .nxt_min (nxt_min),
    .nxt_max (nxt_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_mean  <= '0;
    end else if (close_acc) begin
      out_valid <= 1'b1;
      out_sum   <= nxt_sum;
      out_min   <= nxt_min;
      out_max   <= nxt_max;
      out_mean  <= DATA_W'(nxt_sum >> WIN_LOG2);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spu_window_stats.sv
// Scoreboard bench for spu_window_stats (WIN=4).
// Directed samples; monitor pops expected records on each drain.
module tb_spu_window_stats;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] out_mean;

  typedef struct {
    int s;
    int mn;
    int mx;
    int mean;
  } rec_t;

  rec_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   stalls = 0;

  spu_window_stats #(
    .DATA_W   (8),
    .WIN_LOG2 (2),
    .ACC_W    (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_mean  (out_mean)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push(input int s, input int mn, input int mx,
                      input int mean);
    rec_t r;
    r.s = s; r.mn = mn; r.mx = mx; r.mean = mean;
    exp_q.push_back(r);
  endtask

  // Monitor: a record transfers at the next edge when valid and ready
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record_sum", int'(out_sum), -1);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("rec_sum", int'(out_sum), r.s);
        chk("rec_min", int'(out_min), r.mn);
        chk("rec_max", int'(out_max), r.mx);
        chk("rec_mean", int'(out_mean), r.mean);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_one(input int d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sum", int'(out_sum), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // basic window
    push(270, 3, 250, 67);
    send_one(10); send_one(3); send_one(250); send_one(7);
    idle(1);
    chk("single_cycle_valid", int'(out_valid), 0);
    drain();

    // extremes
    push(1020, 255, 255, 255);
    push(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send_one(255);
    for (int i = 0; i < 4; i++) send_one(0);
    drain();

    // backpressure at window close
    out_ready = 1'b0;
    push(10, 1, 4, 2);
    push(26, 5, 8, 6);
    for (int i = 1; i <= 7; i++) send_one(i);
    in_data = 8'd8;
    @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("held_valid", int'(out_valid), 1);
    chk("held_sum", int'(out_sum), 10);
    @(negedge clk);
    chk("held_sum_stable", int'(out_sum), 10);
    chk("held_max_stable", int'(out_max), 4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_one(8);
    chk("replace_valid", int'(out_valid), 1);
    drain();

    // back-to-back throughput
    pop_cyc.delete();
    stalls = 0;
    push(10, 1, 4, 2);
    push(26, 5, 8, 6);
    push(42, 9, 12, 10);
    for (int i = 1; i <= 12; i++) send_one(i);
    drain();
    idle(3);
    chk("b2b_records", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap0", pop_cyc[1] - pop_cyc[0], 4);
      chk("b2b_gap1", pop_cyc[2] - pop_cyc[1], 4);
    end
    chk("b2b_stalls", stalls, 0);

    // clear discards the partial window
    push(10, 1, 4, 2);
    send_one(9); send_one(9);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    send_one(1); send_one(2); send_one(3); send_one(4);
    drain();

    // reset with a record pending and a partial window
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_one(i);
    send_one(7); send_one(7); send_one(7);
    in_valid = 1'b0;
    chk("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_min", int'(out_min), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_mean", int'(out_mean), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push(20, 2, 8, 5);
    send_one(2); send_one(4); send_one(6); send_one(8);
    drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
